flags_ctrl: RTL and testbench

Run-control and flag-write sequencer for the i281 flags register. It owns the `run` and flag-write-enable/data signals that drive the flags register. It arbitrates flag writes between the ALU (decoder c14 path) and the host/debug port, and evaluates conditional-branch conditions against the flags. It sits between the control decoder, the debug host interface and the flags register.

---
 rtl/flags_ctrl_if.sv | 54 +++++
 rtl/flags_ctrl.sv | 147 ++++++++++++++
 tb/tb_flags_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/flags_ctrl_if.sv
// -----------------------------------------------------------------------------
// flags_ctrl_if
// Bundles every non-clock signal of the flags run-control sequencer.
//   slave  modport : view used by flags_ctrl (requests in, run/flag/branch out)
//   master modport : view used by the surrounding decoder / host / testbench
// Signals:
//   run_req, step_req, halt_req : single-cycle run-control pulses
//   c14, alu_flags              : ALU flag-update request and data {C,N,V,Z}
//   host_wr, host_flags         : host/debug flag write
//   flags_cur                   : current flags register contents
//   br_req, br_cond             : branch evaluation request and condition code
//   push, pop                   : shadow save/restore (used only with FLAGS_SHADOW_EN)
//   run, flag_we, flag_wdata    : execution enable and flags register write port
//   br_valid, br_taken          : branch result
//   host_err                    : host write rejected while running
//   cycle_cnt, state            : executed-cycle counter and FSM state (debug)
// -----------------------------------------------------------------------------
interface flags_ctrl_if #(
    parameter int CNT_W  = 16,
    parameter int COND_W = 3
);
    logic              run_req;
    logic              step_req;
    logic              halt_req;
    logic              c14;
    logic [3:0]        alu_flags;
    logic              host_wr;
    logic [3:0]        host_flags;
    logic [3:0]        flags_cur;
    logic              br_req;
    logic [COND_W-1:0] br_cond;
    logic              push;
    logic              pop;
    logic              run;
    logic              flag_we;
    logic [3:0]        flag_wdata;
    logic              br_valid;
    logic              br_taken;
    logic              host_err;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [1:0]        state;

    modport slave (
        input  run_req, step_req, halt_req, c14, alu_flags, host_wr, host_flags,
               flags_cur, br_req, br_cond, push, pop,
        output run, flag_we, flag_wdata, br_valid, br_taken, host_err, cycle_cnt, state
    );

    modport master (
        output run_req, step_req, halt_req, c14, alu_flags, host_wr, host_flags,
               flags_cur, br_req, br_cond, push, pop,
        input  run, flag_we, flag_wdata, br_valid, br_taken, host_err, cycle_cnt, state
    );
endinterface

// File: rtl/flags_ctrl.sv
// -----------------------------------------------------------------------------
// flags_ctrl
// Run-control and flag-write sequencer for the i281 flags register.
// Ports:
//   clock : system clock
//   reset : synchronous, active-low reset
//   bus   : flags_ctrl_if.slave (run control, flag write arbitration,
//           branch evaluation, debug state/counter)
// Optional feature macro: FLAGS_SHADOW_EN adds a 4-bit shadow register driven
// by push/pop; without it push/pop are ignored.
//
// Handshake: br_req is a one-cycle request sampled at posedge; the result is
// presented as br_valid=1 with br_taken for exactly one cycle, one cycle later.
// There is no ready/back-pressure: each request yields one result, so requests
// on consecutive cycles produce results on consecutive cycles.
// -----------------------------------------------------------------------------
module flags_ctrl #(
    parameter int CNT_W  = 16,
    parameter int COND_W = 3
) (
    input  logic clock,
    input  logic reset,
    flags_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_STEP = 2'b10;
    localparam logic [1:0] S_HALT = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       wdata_q, wdata_d;
    logic             host_err_q, host_err_d;
    logic             br_valid_q, br_valid_d;
    logic             br_taken_q, br_taken_d;
    logic             run;
    logic             flag_we;
    logic [3:0]       fwd_flags;
    logic             cond_ok;

    assign run = (state_q == S_RUN) || (state_q == S_STEP);

    // Next state; halt_req has priority over step_req over run_req.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (bus.halt_req)      state_d = state_q;
                else if (bus.step_req) state_d = S_STEP;
                else if (bus.run_req)  state_d = S_RUN;
            end
            S_RUN:   if (bus.halt_req) state_d = S_HALT;
            default: state_d = S_HALT;  // STEP lasts exactly one cycle
        endcase
    end

`ifdef FLAGS_SHADOW_EN
    logic [3:0] shadow_q, shadow_d;
`else
    logic unused_shadow_ins;
    assign unused_shadow_ins = bus.push ^ bus.pop;
`endif

    // Flag write arbitration. wdata_d doubles as the held value when no write.
    always_comb begin
        flag_we = 1'b0;
        wdata_d = wdata_q;
`ifdef FLAGS_SHADOW_EN
        if (run && bus.pop) begin
            flag_we = 1'b1;
            wdata_d = shadow_q;
        end else
`endif
        if (run && bus.c14) begin
            flag_we = 1'b1;
            wdata_d = bus.alu_flags;
        end else if (!run && bus.host_wr) begin
            flag_we = 1'b1;
            wdata_d = bus.host_flags;
        end
    end

    // Branches see a flag write happening in the same cycle.
    assign fwd_flags = flag_we ? wdata_d : bus.flags_cur;

`ifdef FLAGS_SHADOW_EN
    // pop wins over push, so a simultaneous push leaves the shadow alone.
    always_comb begin
        shadow_d = shadow_q;
        if (run && bus.push && !bus.pop) shadow_d = fwd_flags;
    end
`endif

    // Condition evaluation; flags are {C,N,V,Z}.
    always_comb begin
        cond_ok = 1'b0;
        case (bus.br_cond)
            COND_W'(0): cond_ok = 1'b1;
            COND_W'(1): cond_ok = fwd_flags[0];
            COND_W'(2): cond_ok = !fwd_flags[0];
            COND_W'(3): cond_ok = fwd_flags[2] ^ fwd_flags[1];
            COND_W'(4): cond_ok = !(fwd_flags[2] ^ fwd_flags[1]);
            COND_W'(5): cond_ok = fwd_flags[3];
            COND_W'(6): cond_ok = !fwd_flags[3];
            COND_W'(7): cond_ok = !fwd_flags[0] && !(fwd_flags[2] ^ fwd_flags[1]);
            default:    cond_ok = 1'b0;
        endcase
    end

    assign cnt_d      = run ? cnt_q + CNT_W'(1) : cnt_q;
    assign host_err_d = run && bus.host_wr;
    assign br_valid_d = bus.br_req;
    assign br_taken_d = bus.br_req && cond_ok;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            wdata_q    <= 4'b0000;
            host_err_q <= 1'b0;
            br_valid_q <= 1'b0;
            br_taken_q <= 1'b0;
`ifdef FLAGS_SHADOW_EN
            shadow_q   <= 4'b0000;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wdata_q    <= wdata_d;
            host_err_q <= host_err_d;
            br_valid_q <= br_valid_d;
            br_taken_q <= br_taken_d;
`ifdef FLAGS_SHADOW_EN
            shadow_q   <= shadow_d;
`endif
        end
    end

    assign bus.run        = run;
    assign bus.flag_we    = flag_we;
    assign bus.flag_wdata = wdata_d;
    assign bus.br_valid   = br_valid_q;
    assign bus.br_taken   = br_taken_q;
    assign bus.host_err   = host_err_q;
    assign bus.cycle_cnt  = cnt_q;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_flags_ctrl.sv
module tb_flags_ctrl;
    logic clock;
    logic reset;
    int   n_chk;
    int   n_fail;
    logic exp_q[$];

    flags_ctrl_if bus ();

    flags_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        bus.run_req    = 1'b0;
        bus.step_req   = 1'b0;
        bus.halt_req   = 1'b0;
        bus.c14        = 1'b0;
        bus.alu_flags  = 4'h0;
        bus.host_wr    = 1'b0;
        bus.host_flags = 4'h0;
        bus.flags_cur  = 4'h0;
        bus.br_req     = 1'b0;
        bus.br_cond    = 3'd0;
        bus.push       = 1'b0;
        bus.pop        = 1'b0;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference condition model; f = {C,N,V,Z}.
    function automatic logic cond_model(input logic [2:0] cond, input logic [3:0] f);
        logic c, n, v, z;
        c = f[3]; n = f[2]; v = f[1]; z = f[0];
        case (cond)
            3'd0:    return 1'b1;
            3'd1:    return z;
            3'd2:    return ~z;
            3'd3:    return n != v;
            3'd4:    return n == v;
            3'd5:    return c;
            3'd6:    return ~c;
            default: return (~z) & (n == v);
        endcase
    endfunction

    task automatic drive_br(input logic [2:0] cond, input logic [3:0] f_exp);
        bus.br_req  = 1'b1;
        bus.br_cond = cond;
        exp_q.push_back(cond_model(cond, f_exp));
    endtask

    task automatic check_br();
        if (exp_q.size() > 0) begin
            check("br_valid", {15'd0, bus.br_valid}, 16'd1);
            check("br_taken", {15'd0, bus.br_taken}, {15'd0, exp_q.pop_front()});
        end else begin
            check("br_valid_idle", {15'd0, bus.br_valid}, 16'd0);
        end
    endtask

    task automatic check_reset_state();
        check("rst_state",    {14'd0, bus.state},      16'd0);
        check("rst_run",      {15'd0, bus.run},        16'd0);
        check("rst_flag_we",  {15'd0, bus.flag_we},    16'd0);
        check("rst_wdata",    {12'd0, bus.flag_wdata}, 16'd0);
        check("rst_br_valid", {15'd0, bus.br_valid},   16'd0);
        check("rst_br_taken", {15'd0, bus.br_taken},   16'd0);
        check("rst_host_err", {15'd0, bus.host_err},   16'd0);
        check("rst_cnt",      bus.cycle_cnt,           16'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [3:0] f;
        n_chk  = 0;
        n_fail = 0;
        idle_inputs();
        reset = 1'b0;
        tick(); tick();
        check_reset_state();
        reset = 1'b1;

        // Continuous run, counter 1,2,3, then halt freezes it.
        bus.run_req = 1'b1; tick(); bus.run_req = 1'b0;
        check("run_state", {14'd0, bus.state}, 16'd1);
        check("run_run",   {15'd0, bus.run},   16'd1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("run_cnt", bus.cycle_cnt, 16'(i));
        end
        bus.halt_req = 1'b1; tick(); bus.halt_req = 1'b0;
        check("halt_state", {14'd0, bus.state}, 16'd3);
        check("halt_run",   {15'd0, bus.run},   16'd0);
        check("halt_cnt",   bus.cycle_cnt,      16'd4);
        tick();
        check("halt_cnt_frozen", bus.cycle_cnt, 16'd4);

        // Single step with an ALU flag write in the step cycle.
        bus.step_req = 1'b1; tick(); bus.step_req = 1'b0;
        bus.c14 = 1'b1; bus.alu_flags = 4'b0001; #1;
        check("step_run",   {15'd0, bus.run},        16'd1);
        check("step_we",    {15'd0, bus.flag_we},    16'd1);
        check("step_wdata", {12'd0, bus.flag_wdata}, 16'h1);
        tick(); bus.c14 = 1'b0; #1;
        check("step_state", {14'd0, bus.state},      16'd3);
        check("step_run0",  {15'd0, bus.run},        16'd0);
        check("step_hold",  {12'd0, bus.flag_wdata}, 16'h1);
        check("step_cnt",   bus.cycle_cnt,           16'd5);
        tick();
        check("step_once",  bus.cycle_cnt,           16'd5);

        // Host write accepted while halted.
        bus.host_wr = 1'b1; bus.host_flags = 4'hF; #1;
        check("host_halt_we",    {15'd0, bus.flag_we},    16'd1);
        check("host_halt_wdata", {12'd0, bus.flag_wdata}, 16'hF);
        tick(); bus.host_wr = 1'b0;
        check("host_halt_err",   {15'd0, bus.host_err},   16'd0);

        // Host write rejected while running.
        bus.run_req = 1'b1; tick(); bus.run_req = 1'b0;
        bus.host_wr = 1'b1; bus.host_flags = 4'h6; #1;
        check("host_run_we",    {15'd0, bus.flag_we},    16'd0);
        check("host_run_wdata", {12'd0, bus.flag_wdata}, 16'hF);
        tick(); bus.host_wr = 1'b0;
        check("host_run_err",   {15'd0, bus.host_err},   16'd1);
        tick();
        check("host_err_pulse", {15'd0, bus.host_err},   16'd0);

        // Forwarded branch: N=1,V=0 written this cycle, signed LT.
        bus.c14 = 1'b1; bus.alu_flags = 4'b0100; bus.flags_cur = 4'b0000;
        drive_br(3'd3, 4'b0100);
        tick(); bus.c14 = 1'b0; bus.br_req = 1'b0;
        check_br();
        // No write, flags_cur=0, Z condition.
        drive_br(3'd1, 4'b0000);
        tick(); bus.br_req = 1'b0;
        check_br();

        // Back-to-back branches while running, random flags/writes.
        for (int i = 0; i < 8; i++) begin
            bus.flags_cur = 4'($urandom_range(0, 15));
            bus.alu_flags = 4'($urandom_range(0, 15));
            bus.c14       = 1'($urandom_range(0, 1));
            f = bus.c14 ? bus.alu_flags : bus.flags_cur;
            drive_br(3'(i), f);
            tick();
            check_br();
        end
        bus.br_req = 1'b0; bus.c14 = 1'b0;
        tick();
        check_br();

        // Branches while halted: host writes forward, c14 is ignored.
        bus.halt_req = 1'b1; tick(); bus.halt_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.flags_cur  = 4'($urandom_range(0, 15));
            bus.host_flags = 4'($urandom_range(0, 15));
            bus.alu_flags  = 4'($urandom_range(0, 15));
            bus.host_wr    = 1'($urandom_range(0, 1));
            bus.c14        = 1'($urandom_range(0, 1));
            f = bus.host_wr ? bus.host_flags : bus.flags_cur;
            drive_br(3'(7 - i), f);
            tick();
            check_br();
        end
        bus.br_req = 1'b0; bus.host_wr = 1'b0; bus.c14 = 1'b0;
        tick();
        check_br();

        // Shadow save/restore.
        bus.run_req = 1'b1; tick(); bus.run_req = 1'b0;
`ifdef FLAGS_SHADOW_EN
        bus.flags_cur = 4'b1010; bus.push = 1'b1;
        tick(); bus.push = 1'b0;
        bus.c14 = 1'b1; bus.alu_flags = 4'b0000; #1;
        check("shd_c14_wdata", {12'd0, bus.flag_wdata}, 16'h0);
        tick();
        bus.pop = 1'b1; bus.alu_flags = 4'b0101; #1;
        check("shd_pop_we",    {15'd0, bus.flag_we},    16'd1);
        check("shd_pop_wdata", {12'd0, bus.flag_wdata}, 16'hA);
        tick();
        bus.push = 1'b1; bus.flags_cur = 4'b0011; #1;
        check("shd_both_wdata", {12'd0, bus.flag_wdata}, 16'hA);
        tick(); bus.push = 1'b0; #1;
        check("shd_unchanged", {12'd0, bus.flag_wdata}, 16'hA);
        tick(); bus.pop = 1'b0; bus.c14 = 1'b0;
`else
        bus.pop = 1'b1; bus.push = 1'b1; bus.flags_cur = 4'b1010; #1;
        check("noshd_pop_we", {15'd0, bus.flag_we}, 16'd0);
        tick(); bus.pop = 1'b0; bus.push = 1'b0;
`endif

        // Reset while running aborts a pending branch.
        bus.br_req = 1'b1; bus.br_cond = 3'd0;
        reset = 1'b0; tick(); bus.br_req = 1'b0;
        check_reset_state();
        reset = 1'b1;

        // Counter wrap.
        bus.run_req = 1'b1; tick(); bus.run_req = 1'b0;
        check("wrap_start", bus.cycle_cnt, 16'd0);
        repeat (65535) tick();
        check("wrap_max", bus.cycle_cnt, 16'hFFFF);
        tick();
        check("wrap_zero", bus.cycle_cnt, 16'd0);
        tick();
        check("wrap_one", bus.cycle_cnt, 16'd1);

        reset = 1'b0; tick();
        check_reset_state();
        reset = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
